// File: rtl/lcd_timing_gen.sv
// LCD timing generator and pixel FIFO consumer.
// Produces HS/VS/DE plus pixel data for the panel. The FIFO data request is
// issued REQ_LEAD clocks ahead of DE so that returning data lines up with the
// active pixels. The returned read strobe is tracked to detect underflow;
// missing pixels are replaced with FILL_COLOR and counted.
module lcd_timing_gen #(
    parameter int                 H_SYNC     = 128,
    parameter int                 H_BP       = 88,
    parameter int                 H_ACTIVE   = 800,
    parameter int                 H_FP       = 40,
    parameter int                 V_SYNC     = 3,
    parameter int                 V_BP       = 21,
    parameter int                 V_ACTIVE   = 480,
    parameter int                 V_FP       = 1,
    parameter int                 DATA_W     = 16,
    parameter int                 REQ_LEAD   = 3,
    parameter int                 RD_LATENCY = 1,
    parameter bit                 SYNC_POL   = 1'b0,
    parameter logic [DATA_W-1:0]  FILL_COLOR = '0
) (
    input  logic              fifo_rd_clk,
    input  logic              rst_n,
    input  logic              lcd_en,
    input  logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              err_clr,
    output logic              rd_data_requst,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_data,
    output logic              frame_start,
    output logic              busy,
    output logic              underflow_flag,
    output logic [15:0]       underflow_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // One extra bit of headroom so window end points never alias to 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_DE_START  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_DE_END    = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HW-1:0] H_REQ_START = HW'(H_SYNC + H_BP - REQ_LEAD);
    localparam logic [HW-1:0] H_REQ_END   = HW'(H_SYNC + H_BP + H_ACTIVE - REQ_LEAD);

    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_DE_START  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_DE_END    = VW'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t                state_reg;
    logic [HW-1:0]         h_cnt_reg;
    logic [VW-1:0]         v_cnt_reg;
    logic [HW-1:0]         h_next;
    logic [VW-1:0]         v_next;
    logic                  h_at_last;
    logic                  v_at_last;
    logic                  active;

    logic                  hs_win;
    logic                  vs_win;
    logic                  de_next;
    logic                  req_next;
    logic                  v_active_line;

    logic [RD_LATENCY-1:0] dv_pipe_reg;
    logic [RD_LATENCY-1:0] dv_pipe_next;
    logic                  dv;
    logic                  underflow_event;

    logic                  hs_reg;
    logic                  vs_reg;
    logic                  de_reg;
    logic                  req_reg;
    logic                  frame_start_reg;
    logic [DATA_W-1:0]     data_reg;
    logic                  underflow_flag_reg;
    logic [15:0]           underflow_cnt_reg;

    assign h_at_last = (h_cnt_reg == H_LAST);
    assign v_at_last = (v_cnt_reg == V_LAST);
    assign active    = (state_reg != IDLE);

    // Next raster position: h wraps into a v increment, v wraps at frame end.
    always_comb begin
        h_next = h_cnt_reg + 1'b1;
        v_next = v_cnt_reg;
        if (h_at_last) begin
            h_next = '0;
            v_next = v_at_last ? '0 : v_cnt_reg + 1'b1;
        end
    end

    // Timing windows decoded from the current raster position.
    always_comb begin
        v_active_line = (v_cnt_reg >= V_DE_START) && (v_cnt_reg < V_DE_END);
        hs_win        = (h_cnt_reg < H_SYNC_END);
        vs_win        = (v_cnt_reg < V_SYNC_END);
        de_next       = active && v_active_line &&
                        (h_cnt_reg >= H_DE_START) && (h_cnt_reg < H_DE_END);
        req_next      = active && v_active_line &&
                        (h_cnt_reg >= H_REQ_START) && (h_cnt_reg < H_REQ_END);
    end

    // Run-control FSM and raster counters; STOPPING finishes the frame before idling.
    always_ff @(posedge fifo_rd_clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= '0;
                    if (lcd_en) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    h_cnt_reg <= h_next;
                    v_cnt_reg <= v_next;
                    if (!lcd_en) begin
                        state_reg <= STOPPING;
                    end
                end
                STOPPING: begin
                    h_cnt_reg <= h_next;
                    v_cnt_reg <= v_next;
                    if (lcd_en) begin
                        state_reg <= RUN;
                    end else if (h_at_last && v_at_last) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    h_cnt_reg <= '0;
                    v_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Data-valid delay line input: stage 0 takes the read strobe, later stages chain.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_dv
            if (gi == 0) begin : g_first
                assign dv_pipe_next[gi] = fifo_rd_en;
            end else begin : g_chain
                assign dv_pipe_next[gi] = dv_pipe_reg[gi-1];
            end
        end
    endgenerate

    assign dv              = dv_pipe_reg[RD_LATENCY-1];
    assign underflow_event = de_next && !dv;

    // Delay the read strobe so it lines up with the data it fetched.
    always_ff @(posedge fifo_rd_clk) begin
        if (!rst_n) begin
            dv_pipe_reg <= '0;
        end else begin
            dv_pipe_reg <= dv_pipe_next;
        end
    end

    // Registered panel outputs, one clock behind the raster counters.
    always_ff @(posedge fifo_rd_clk) begin
        if (!rst_n) begin
            hs_reg          <= ~SYNC_POL;
            vs_reg          <= ~SYNC_POL;
            de_reg          <= 1'b0;
            req_reg         <= 1'b0;
            frame_start_reg <= 1'b0;
            data_reg        <= '0;
        end else begin
            hs_reg          <= (active && hs_win) ? SYNC_POL : ~SYNC_POL;
            vs_reg          <= (active && vs_win) ? SYNC_POL : ~SYNC_POL;
            de_reg          <= de_next;
            req_reg         <= req_next;
            frame_start_reg <= active && (h_cnt_reg == '0) && (v_cnt_reg == '0);
            if (de_next) begin
                data_reg <= dv ? fifo_rd_data : FILL_COLOR;
            end else begin
                data_reg <= '0;
            end
        end
    end

    // Sticky underflow flag and saturating pixel count; a clear beats a new event.
    always_ff @(posedge fifo_rd_clk) begin
        if (!rst_n) begin
            underflow_flag_reg <= 1'b0;
            underflow_cnt_reg  <= '0;
        end else if (err_clr) begin
            underflow_flag_reg <= 1'b0;
            underflow_cnt_reg  <= '0;
        end else if (underflow_event) begin
            underflow_flag_reg <= 1'b1;
            if (underflow_cnt_reg != 16'hFFFF) begin
                underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
            end
        end
    end

    assign rd_data_requst = req_reg;
    assign lcd_hs         = hs_reg;
    assign lcd_vs         = vs_reg;
    assign lcd_de         = de_reg;
    assign lcd_data       = data_reg;
    assign frame_start    = frame_start_reg;
    assign busy           = active;
    assign underflow_flag = underflow_flag_reg;
    assign underflow_cnt  = underflow_cnt_reg;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen using a small 14x7 raster (2/2/8/2, 1/1/4/1).
// An ideal FIFO reader answers each request one clock later with incrementing
// data; it can be told to withhold reads to provoke underflow.
module tb_lcd_timing_gen;

    localparam logic [15:0] FILL = 16'hDEAD;

    logic        clk;
    logic        rst_n;
    logic        lcd_en;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        err_clr;
    logic        rd_data_requst;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [15:0] lcd_data;
    logic        frame_start;
    logic        busy;
    logic        underflow_flag;
    logic [15:0] underflow_cnt;

    // Reader model controls
    logic        rdr_rst;
    logic        withhold;
    logic [15:0] rd_ctr;

    int n_checks;
    int n_fail;
    int exp_ctr;
    int cur_pos;

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .DATA_W(16), .REQ_LEAD(3), .RD_LATENCY(1),
        .SYNC_POL(1'b0), .FILL_COLOR(FILL)
    ) dut (
        .fifo_rd_clk   (clk),
        .rst_n         (rst_n),
        .lcd_en        (lcd_en),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .err_clr       (err_clr),
        .rd_data_requst(rd_data_requst),
        .lcd_hs        (lcd_hs),
        .lcd_vs        (lcd_vs),
        .lcd_de        (lcd_de),
        .lcd_data      (lcd_data),
        .frame_start   (frame_start),
        .busy          (busy),
        .underflow_flag(underflow_flag),
        .underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal reader: read strobe follows request by one clock, data one clock after the strobe.
    always @(posedge clk) begin
        if (rdr_rst) begin
            fifo_rd_en   <= 1'b0;
            fifo_rd_data <= 16'h0;
            rd_ctr       <= 16'h0;
        end else begin
            fifo_rd_en <= rd_data_requst && !withhold;
            if (fifo_rd_en) begin
                fifo_rd_data <= rd_ctr;
                rd_ctr       <= rd_ctr + 16'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, cur_pos, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_req", rd_data_requst, 0);
        chk("rst_de", lcd_de, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_hs", lcd_hs, 1);
        chk("rst_vs", lcd_vs, 1);
        chk("rst_fs", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_uflag", underflow_flag, 0);
        chk("rst_ucnt", underflow_cnt, 0);
    endtask

    // Check all panel outputs for raster position pos (as seen on the registered outputs).
    task automatic check_cycle(input int pos, input bit act, input bit busy_exp, input bit wh_line);
        int h;
        int v;
        bit e_de;
        bit e_req;
        bit miss;
        logic [15:0] e_data;
        h = pos % 14;
        v = pos / 14;
        cur_pos = pos;
        e_de  = act && h >= 4 && h < 12 && v >= 2 && v < 6;
        e_req = act && h >= 1 && h < 9 && v >= 2 && v < 6;
        miss  = e_de && wh_line && v == 3 && h >= 4 && h <= 6;
        if (!e_de) begin
            e_data = 16'h0;
        end else if (miss) begin
            e_data = FILL;
        end else begin
            e_data = 16'(exp_ctr);
            exp_ctr++;
        end
        chk("hs", lcd_hs, (act && h < 2) ? 0 : 1);
        chk("vs", lcd_vs, (act && v < 1) ? 0 : 1);
        chk("de", lcd_de, e_de);
        chk("req", rd_data_requst, e_req);
        chk("fs", frame_start, (act && pos == 0) ? 1 : 0);
        chk("data", lcd_data, e_data);
        chk("busy", busy, busy_exp);
        // Suppress the first three reads of active line v=3 -> pixels h=4..6 go missing
        withhold = act && wh_line && v == 3 && h >= 1 && h <= 3;
    endtask

    task automatic wait_fs();
        int k;
        for (k = 0; k < 300 && !frame_start; k++) @(negedge clk);
        chk("fs_wait", frame_start, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ctr  = 0;
        cur_pos  = 0;
        rst_n    = 1'b0;
        lcd_en   = 1'b0;
        err_clr  = 1'b0;
        rdr_rst  = 1'b1;
        withhold = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();

        // Start: three frames, underflow injected in frame 1, cleared at start of frame 2
        rst_n   = 1'b1;
        rdr_rst = 1'b0;
        lcd_en  = 1'b1;
        wait_fs();
        for (int c = 0; c < 3 * 98; c++) begin
            check_cycle(c % 98, 1'b1, 1'b1, (c / 98) == 1);
            if (c == 97) begin
                chk("uflag_f0", underflow_flag, 0);
                chk("ucnt_f0", underflow_cnt, 0);
            end
            if (c == 2 * 98) begin
                chk("uflag_set", underflow_flag, 1);
                chk("ucnt_3", underflow_cnt, 3);
                err_clr = 1'b1;
            end
            if (c == 2 * 98 + 1) begin
                err_clr = 1'b0;
                chk("uflag_clr", underflow_flag, 0);
                chk("ucnt_clr", underflow_cnt, 0);
            end
            @(negedge clk);
        end

        // Drop enable mid-frame: frame completes, busy falls at the wrap
        for (int p = 0; p < 98; p++) begin
            check_cycle(p, 1'b1, p != 97, 1'b0);
            if (p == 50) lcd_en = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 20; k++) begin
            check_cycle(0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Restart, then drop and re-raise enable within a frame: no frame break
        lcd_en = 1'b1;
        wait_fs();
        for (int c = 0; c < 2 * 98; c++) begin
            check_cycle(c % 98, 1'b1, 1'b1, 1'b0);
            if (c == 30) lcd_en = 1'b0;
            if (c == 60) lcd_en = 1'b1;
            @(negedge clk);
        end
        chk("ucnt_none", underflow_cnt, 0);

        // Saturation: preload count near the top, then three underflows
        for (int p = 0; p < 98; p++) begin
            check_cycle(p, 1'b1, 1'b1, 1'b1);
            if (p == 0) begin
                force dut.underflow_cnt_reg = 16'hFFFE;
                #1;
                release dut.underflow_cnt_reg;
            end
            if (p == 1)  chk("ucnt_pre", underflow_cnt, 16'hFFFE);
            if (p == 46) chk("ucnt_sat1", underflow_cnt, 16'hFFFF);
            if (p == 47) chk("ucnt_sat2", underflow_cnt, 16'hFFFF);
            if (p == 97) begin
                chk("ucnt_sat3", underflow_cnt, 16'hFFFF);
                chk("uflag_sat", underflow_flag, 1);
            end
            @(negedge clk);
        end

        // Mid-active-line reset
        for (int p = 0; p <= 49; p++) begin
            check_cycle(p, 1'b1, 1'b1, 1'b0);
            if (p < 49) @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        cur_pos = -1;
        chk_reset_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
